// File: rtl/cpu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_mem_arbiter
//
// Shares the single-port CPU data memory between instruction fetch (IF,
// read-only), CPU load/store (DM) and the VPU. One access is in flight at a
// time, sequenced IDLE -> ISSUE -> (WAIT ->) IDLE. Read data comes back on a
// shared registered rdata bus with a per-requester one-cycle valid pulse.
//
// Optional feature macro: MEM_ARB_STARVE_EN
//   When defined, VPU and IF each keep a lost-arbitration counter. A
//   requester whose counter has reached STARVE_MAX wins the next arbitration
//   it takes part in (VPU before IF). When undefined, priority is a plain
//   fixed DM > VPU > IF.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                instruction fetch read request
//   dm_req/dm_we/dm_addr/dm_wdata CPU load/store request
//   vpu_req/vpu_we/vpu_addr/...   VPU load/store request
//   *_gnt                         one-cycle grant pulse (ISSUE cycle)
//   *_rvalid                      one-cycle read-data-valid pulse
//   rdata                         registered read data, held between pulses
//   mem_en/mem_we/mem_addr/...    memory macro access port
//   mem_rdata                     memory read data, MEM_LAT cycles after mem_en
// -----------------------------------------------------------------------------
module cpu_mem_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,

    input  logic              vpu_req,
    input  logic              vpu_we,
    input  logic [ADDR_W-1:0] vpu_addr,
    input  logic [DATA_W-1:0] vpu_wdata,

    output logic              if_gnt,
    output logic              dm_gnt,
    output logic              vpu_gnt,

    output logic              if_rvalid,
    output logic              dm_rvalid,
    output logic              vpu_rvalid,
    output logic [DATA_W-1:0] rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
    localparam int unsigned NREQ  = 3;

    // One-hot requester positions used by the grant/valid vectors.
    localparam int unsigned IDX_IF  = 0;
    localparam int unsigned IDX_DM  = 1;
    localparam int unsigned IDX_VPU = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_t;

    state_e            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   rvalid_q;
    logic [NREQ-1:0]   owner_q;
    logic [CNT_W-1:0]  lat_q;
    logic [CNT_W-1:0]  lat_d;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [NREQ-1:0]   req_vec;
    logic [NREQ-1:0]   win_oh;
    acc_t              win_acc;

    assign req_vec = {vpu_req, dm_req, if_req};

`ifdef MEM_ARB_STARVE_EN
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    logic [STV_W-1:0] vpu_starve_q;
    logic [STV_W-1:0] if_starve_q;
    logic             vpu_sat;
    logic             if_sat;

    assign vpu_sat = (vpu_starve_q == STV_W'(STARVE_MAX));
    assign if_sat  = (if_starve_q  == STV_W'(STARVE_MAX));
`else
    // STARVE_MAX only sizes the starvation counters, which this build omits.
    logic [31:0] unused_starve_max;
    assign unused_starve_max = 32'(STARVE_MAX);
`endif

    // Winner select: fixed DM > VPU > IF, overridden by a saturated starver.
    always_comb begin
        win_oh = '0;
        if (dm_req) begin
            win_oh[IDX_DM] = 1'b1;
        end else if (vpu_req) begin
            win_oh[IDX_VPU] = 1'b1;
        end else if (if_req) begin
            win_oh[IDX_IF] = 1'b1;
        end
`ifdef MEM_ARB_STARVE_EN
        if (vpu_req && vpu_sat) begin
            win_oh = '0;
            win_oh[IDX_VPU] = 1'b1;
        end else if (if_req && if_sat) begin
            win_oh = '0;
            win_oh[IDX_IF] = 1'b1;
        end
`endif
    end

    // Payload of the winning requester; IF never writes.
    always_comb begin
        win_acc.we    = 1'b0;
        win_acc.addr  = if_addr;
        win_acc.wdata = '0;
        if (win_oh[IDX_DM]) begin
            win_acc.we    = dm_we;
            win_acc.addr  = dm_addr;
            win_acc.wdata = dm_wdata;
        end else if (win_oh[IDX_VPU]) begin
            win_acc.we    = vpu_we;
            win_acc.addr  = vpu_addr;
            win_acc.wdata = vpu_wdata;
        end
    end

    assign lat_d = lat_q - CNT_W'(1);

    // Access sequencer; gnt/mem_en/rvalid are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            owner_q     <= '0;
            lat_q       <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef MEM_ARB_STARVE_EN
            vpu_starve_q <= '0;
            if_starve_q  <= '0;
`endif
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            mem_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_vec) begin
                        gnt_q       <= win_oh;
                        owner_q     <= win_oh;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= win_acc.we;
                        mem_addr_q  <= win_acc.addr;
                        mem_wdata_q <= win_acc.wdata;
                        state_q     <= ST_ISSUE;
`ifdef MEM_ARB_STARVE_EN
                        // Count lost arbitrations, saturating; clear on grant.
                        if (win_oh[IDX_VPU]) begin
                            vpu_starve_q <= '0;
                        end else if (vpu_req && !vpu_sat) begin
                            vpu_starve_q <= vpu_starve_q + STV_W'(1);
                        end
                        if (win_oh[IDX_IF]) begin
                            if_starve_q <= '0;
                        end else if (if_req && !if_sat) begin
                            if_starve_q <= if_starve_q + STV_W'(1);
                        end
`endif
                    end
                end
                ST_ISSUE: begin
                    if (mem_we_q) begin
                        state_q <= ST_IDLE;
                    end else begin
                        lat_q   <= CNT_W'(MEM_LAT);
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Counter hits zero in the cycle mem_rdata is valid.
                    lat_q <= lat_d;
                    if (lat_d == '0) begin
                        rdata_q  <= mem_rdata;
                        rvalid_q <= owner_q;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_gnt     = gnt_q[IDX_IF];
    assign dm_gnt     = gnt_q[IDX_DM];
    assign vpu_gnt    = gnt_q[IDX_VPU];
    assign if_rvalid  = rvalid_q[IDX_IF];
    assign dm_rvalid  = rvalid_q[IDX_DM];
    assign vpu_rvalid = rvalid_q[IDX_VPU];
    assign rdata      = rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cpu_mem_arbiter
//
// Randomised requesters against a transaction-level reference: the model
// tracks only "arbiter busy until cycle N", the winner by priority rule, and
// a shadow memory, and from that schedules the cycle of each grant and
// read-valid pulse. A behavioural memory macro answers mem_* accesses.
// -----------------------------------------------------------------------------
module tb_cpu_mem_arbiter;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MEM_LAT    = 2;
    localparam int unsigned STARVE_MAX = 8;

    localparam int NCYC  = 1500;
    localparam int NSLOT = NCYC + 16;
    localparam int MEMSZ = 512;
    localparam int R_IF  = 0;
    localparam int R_DM  = 1;
    localparam int R_VPU = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, dm_req, vpu_req;
    logic              dm_we, vpu_we;
    logic [ADDR_W-1:0] if_addr, dm_addr, vpu_addr;
    logic [DATA_W-1:0] dm_wdata, vpu_wdata;
    logic              if_gnt, dm_gnt, vpu_gnt;
    logic              if_rvalid, dm_rvalid, vpu_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    always #5 clk = ~clk;

    cpu_mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .vpu_req    (vpu_req),
        .vpu_we     (vpu_we),
        .vpu_addr   (vpu_addr),
        .vpu_wdata  (vpu_wdata),
        .if_gnt     (if_gnt),
        .dm_gnt     (dm_gnt),
        .vpu_gnt    (vpu_gnt),
        .if_rvalid  (if_rvalid),
        .dm_rvalid  (dm_rvalid),
        .vpu_rvalid (vpu_rvalid),
        .rdata      (rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    function automatic logic [31:0] init_val(input int a);
        if (a == 'h40) return 32'hDEADBEEF;
        return 32'h1000_0000 + 32'(a) * 32'h0001_0003;
    endfunction

    // Memory macro: write on mem_en&mem_we, read data appears MEM_LAT cycles
    // after mem_en; unrelated cycles show garbage.
    logic [31:0] mem_arr [MEMSZ];
    logic [31:0] rd_pipe [MEM_LAT];
    bit          mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < MEMSZ; i++) mem_arr[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem_arr[mem_addr[8:0]] <= mem_wdata;
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? mem_arr[mem_addr[8:0]] : 32'($urandom);
        for (int i = 1; i < int'(MEM_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign mem_rdata = rd_pipe[MEM_LAT-1];

    int cyc     = 0;
    int n_chk   = 0;
    int n_err   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Expected per-cycle observations.
    logic [2:0]  e_gnt  [NSLOT];
    logic [2:0]  e_rv   [NSLOT];
    logic [31:0] e_rd   [NSLOT];
    logic        e_en   [NSLOT];
    logic        e_we   [NSLOT];
    logic [15:0] e_addr [NSLOT];
    logic [31:0] e_wd   [NSLOT];
    bit          rst_at [NSLOT];

    // Requester state and the reference's shadow memory.
    logic        rq [3];
    logic        rw [3];
    logic [15:0] ra [3];
    logic [31:0] rd [3];
    logic [31:0] ref_mem [MEMSZ];

    task automatic new_request(input int r);
        rq[r] = 1'b1;
        rw[r] = (r == R_IF) ? 1'b0 : 1'($urandom_range(0, 1));
        ra[r] = 16'($urandom_range(0, 63)) * 16'd8;
        rd[r] = $urandom;
    endtask

    initial begin
        int       free_at;
        int       w;
        int       p;
        logic [2:0]  prev_gnt;
        logic [31:0] hold;
`ifdef MEM_ARB_STARVE_EN
        int vpu_lost = 0;
        int if_lost  = 0;
`endif
        for (int k = 0; k < NSLOT; k++) begin
            e_gnt[k] = '0; e_rv[k] = '0; e_rd[k] = '0; e_en[k] = 1'b0;
            e_we[k] = 1'b0; e_addr[k] = '0; e_wd[k] = '0; rst_at[k] = 1'b0;
        end
        for (int i = 0; i < MEMSZ; i++) ref_mem[i] = init_val(i);
        for (int r = 0; r < 3; r++) new_request(r);
        free_at  = 0;
        hold     = '0;
        prev_gnt = '0;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            // Observe this cycle's registered outputs.
            if (cyc > 0) begin
                if (rst_at[cyc-1]) hold = '0;
                if (e_rv[cyc] != '0) hold = e_rd[cyc];
                check("gnt", 64'({vpu_gnt, dm_gnt, if_gnt}), 64'(e_gnt[cyc]));
                check("rvalid", 64'({vpu_rvalid, dm_rvalid, if_rvalid}), 64'(e_rv[cyc]));
                check("rdata", 64'(rdata), 64'(hold));
                check("mem_en", 64'(mem_en), 64'(e_en[cyc]));
                if (e_en[cyc]) begin
                    check("mem_we", 64'(mem_we), 64'(e_we[cyc]));
                    check("mem_addr", 64'(mem_addr), 64'(e_addr[cyc]));
                    if (e_we[cyc]) check("mem_wdata", 64'(mem_wdata), 64'(e_wd[cyc]));
                end else if (rst_at[cyc-1]) begin
                    check("rst_mem_we", 64'(mem_we), 64'd0);
                    check("rst_mem_addr", 64'(mem_addr), 64'd0);
                    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
                end
            end

            // Requesters: move on the cycle after a grant, otherwise maybe raise.
            if (cyc < 400)      p = 30;
            else if (cyc < 700) p = 100;
            else                p = 50;
            for (int r = 0; r < 3; r++) begin
                if (prev_gnt[r]) rq[r] = 1'b0;
                if (cyc >= 2 && !rq[r] && $urandom_range(0, 99) < p) new_request(r);
            end
            prev_gnt = (cyc > 0) ? {vpu_gnt, dm_gnt, if_gnt} : 3'b000;

            rst = (cyc < 2) || (cyc >= 700 && $urandom_range(0, 99) < 3);
            rst_at[cyc] = rst;

            if_req    = rq[R_IF];   if_addr  = ra[R_IF];
            dm_req    = rq[R_DM];   dm_we    = rw[R_DM];  dm_addr  = ra[R_DM];  dm_wdata  = rd[R_DM];
            vpu_req   = rq[R_VPU];  vpu_we   = rw[R_VPU]; vpu_addr = ra[R_VPU]; vpu_wdata = rd[R_VPU];

            // Reference: schedule the outcome of this cycle's arbitration.
            if (rst) begin
                for (int k = cyc + 1; k < NSLOT; k++) begin
                    e_gnt[k] = '0; e_rv[k] = '0; e_en[k] = 1'b0;
                end
                free_at = cyc + 1;
`ifdef MEM_ARB_STARVE_EN
                vpu_lost = 0;
                if_lost  = 0;
`endif
            end else if (cyc >= free_at && (rq[R_IF] || rq[R_DM] || rq[R_VPU])) begin
                if (rq[R_DM])       w = R_DM;
                else if (rq[R_VPU]) w = R_VPU;
                else                w = R_IF;
`ifdef MEM_ARB_STARVE_EN
                if (rq[R_VPU] && vpu_lost == int'(STARVE_MAX))     w = R_VPU;
                else if (rq[R_IF] && if_lost == int'(STARVE_MAX))  w = R_IF;
                if (w == R_VPU) vpu_lost = 0;
                else if (rq[R_VPU] && vpu_lost < int'(STARVE_MAX)) vpu_lost++;
                if (w == R_IF) if_lost = 0;
                else if (rq[R_IF] && if_lost < int'(STARVE_MAX)) if_lost++;
`endif
                e_gnt[cyc+1]  = 3'(1 << w);
                e_en[cyc+1]   = 1'b1;
                e_we[cyc+1]   = rw[w];
                e_addr[cyc+1] = ra[w];
                e_wd[cyc+1]   = rd[w];
                if (rw[w]) begin
                    ref_mem[ra[w][8:0]] = rd[w];
                    free_at = cyc + 2;
                end else begin
                    e_rv[cyc+2+int'(MEM_LAT)] = 3'(1 << w);
                    e_rd[cyc+2+int'(MEM_LAT)] = ref_mem[ra[w][8:0]];
                    free_at = cyc + 2 + int'(MEM_LAT);
                end
            end

            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Shares the single-port CPU data memory between three requesters: instruction fetch (IF, read-only), CPU load/store (DM) and the VPU. It sits between the CPU/VPU ports and the memory macro, sequencing exactly one access at a time through an IDLE/ISSUE/WAIT state machine. It returns read data with a per-requester valid pulse.

## Interface
- ADDR_W, 16, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles from `mem_en` to valid `mem_rdata`; must be ≥1
- STARVE_MAX, 8, lost arbitrations before forced grant (used only with the macro)

- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- if_req / dm_req / vpu_req  in  1  access request; held until matching gnt
- dm_we / vpu_we  in  1  1=write, 0=read; IF always reads
- if_addr / dm_addr / vpu_addr  in  ADDR_W  access address
- dm_wdata / vpu_wdata  in  DATA_W  write data
- if_gnt / dm_gnt / vpu_gnt  out  1  one-cycle grant pulse
- if_rvalid / dm_rvalid / vpu_rvalid  out  1  one-cycle read-data-valid pulse
- rdata  out  DATA_W  registered read data, shared by all requesters
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after `mem_en`

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if any req is high, pick the winner and register addr/we/wdata into the `mem_*` regs, then go to ISSUE. Otherwise stay in IDLE.
- Priority is fixed: DM > VPU > IF.
- ISSUE, one cycle:
  - `mem_en`=1 and the winner's gnt=1.
  - On a write, go to IDLE.
  - On a read, load the latency counter with MEM_LAT and go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 0, capture `mem_rdata` into `rdata`, set the winner's rvalid for the next cycle, and go to IDLE.
- Requester rules:
  - Keep req, addr, we and wdata stable until gnt is sampled high.
  - Drop req, or present a new request, on the cycle after gnt.
  - Reads complete strictly in grant order; only one access is outstanding.
- `mem_we`, `mem_addr` and `mem_wdata` are don't-care when `mem_en`=0 but hold their last value.
- `rdata` holds its value between rvalid pulses.

## Timing
- Reset values: state=IDLE; all gnt/rvalid=0; `mem_en`=0; `mem_we`=0; `mem_addr`=0; `mem_wdata`=0; `rdata`=0; starvation counters=0.
- Read sequence, with req sampled in IDLE at cycle 0:
  - gnt and `mem_en` in cycle 1.
  - `mem_rdata` captured at the end of cycle 1+MEM_LAT.
  - rvalid and `rdata` valid in cycle 2+MEM_LAT.
  - The arbiter is in IDLE during the rvalid cycle and may sample a new request then.
  - Read throughput: one per MEM_LAT+2 cycles.
- Write sequence: gnt and `mem_en`/`mem_we` in cycle 1; IDLE in cycle 2. Throughput: one per 2 cycles.
- Simultaneous requests: exactly one gnt per ISSUE. Losers stay pending and are re-arbitrated in the next IDLE.
- Requests arriving during ISSUE or WAIT are ignored until IDLE.
- Reset mid-access, including in WAIT:
  - Return to reset values the next cycle.
  - The pending read is dropped and no rvalid is issued.
  - The requester must re-request.

## Configuration
- `MEM_ARB_STARVE_EN` defined:
  - VPU and IF each have a counter of width clog2(STARVE_MAX+1).
  - The counter increments on every IDLE arbitration where that req is high and the requester loses, saturating at STARVE_MAX.
  - The counter clears on that requester's grant.
  - A counter equal to STARVE_MAX overrides the fixed priority. If both are saturated, VPU wins before IF.
- Not defined: counters are absent and priority is pure fixed DM > VPU > IF. IF may starve indefinitely.

## Test plan
- Reset check: assert rst for 2 cycles with all reqs high → every output is 0, no gnt, state IDLE.
- IF read, MEM_LAT=2: if_req with if_addr=0x0040, memory model returns 0xDEADBEEF → if_gnt and `mem_en` with `mem_addr`=0x0040 in cycle 1, `mem_we`=0; if_rvalid with `rdata`=0xDEADBEEF in cycle 4.
- Priority: dm write, vpu read and if read all raised in cycle 0 → grant order DM (cycle 1), then VPU (cycle 3), then IF, which is granted 4 cycles after VPU.
- Write then readback: DM writes 0x12345678 to 0x0100, then DM reads 0x0100 → `mem_we`=1 on the first ISSUE only; dm_rvalid with `rdata`=0x12345678.
- Starvation, macro on, STARVE_MAX=4: dm_req and if_req held high continuously → if_gnt on the 5th arbitration, after 4 DM grants. With the macro off → if_gnt never asserts while dm_req is held.
- Reset in WAIT: assert rst during the VPU read WAIT for 1 cycle → no vpu_rvalid ever; a re-issued request completes normally.
